// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA/1080p constants and move FSM state type
// Purpose: common types and constants for the pixel-domain blocks.
//   move_state_t       : per-direction move FSM state (IDLE, DELAY, REPEAT)
//   H_ACTIVE, V_ACTIVE : 1080p active area
//   DEF_*              : default debounce / auto-repeat timing at 148.5 MHz
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } move_state_t;

  localparam int H_ACTIVE            = 1920;
  localparam int V_ACTIVE            = 1080;
  localparam int DEF_DEBOUNCE_CYCLES = 1485000;  // 10 ms of pixel clock
  localparam int DEF_REPEAT_DELAY    = 20;       // frames, first to second pulse
  localparam int DEF_REPEAT_PERIOD   = 4;        // frames between repeat pulses

endpackage

// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - button/frame inputs and move pulse outputs of move_scheduler
// Purpose: bundles the scheduler's board-side inputs and position-side outputs.
//   btn_*_raw   : raw asynchronous buttons (master -> slave)
//   frame_start : VGA frame tick, rising edge acts (master -> slave)
//   enable      : 0 halts the scheduler (master -> slave)
//   move_*      : single-cycle move pulses (slave -> master)
// The scheduler is the slave; the board/timing side is the master.
interface move_scheduler_if;

  logic btn_l_raw;
  logic btn_r_raw;
  logic btn_u_raw;
  logic btn_d_raw;
  logic frame_start;
  logic enable;
  logic move_l;
  logic move_r;
  logic move_u;
  logic move_d;

  modport master (
    output btn_l_raw, btn_r_raw, btn_u_raw, btn_d_raw, frame_start, enable,
    input  move_l, move_r, move_u, move_d
  );

  modport slave (
    input  btn_l_raw, btn_r_raw, btn_u_raw, btn_d_raw, frame_start, enable,
    output move_l, move_r, move_u, move_d
  );

endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchroniser, debouncer and press-pending flag
// Purpose: turns one raw bouncy button into a clean debounced level plus a
// flag remembering a press that has not yet been seen by a frame tick.
//   clk_148Mhz : pixel clock
//   reset      : asynchronous, active-high
//   raw        : raw asynchronous button
//   clr        : clears pending (frame tick or scheduler halted); wins over a new press
//   db         : debounced button level
//   pending    : a debounced press occurred since the last clr
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1485000
) (
  input  logic clk_148Mhz,
  input  logic reset,
  input  logic raw,
  input  logic clr,
  output logic db,
  output logic pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      db      <= 1'b0;
      db_q    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // cnt counts consecutive cycles the synchronised input has disagreed
      // with db; the last disagreeing cycle commits the new level.
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      db_q <= db;
      // A press seen on a tick cycle is served by the FSM's db rule, so the
      // clear must win or the press would be counted twice.
      if (clr) begin
        pending <= 1'b0;
      end else if (db && !db_q) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - frame-aligned move pulse scheduler with debounce and auto-repeat
// Purpose: conditions four direction buttons and issues at most one move
// pulse per direction per frame, with immediate step plus timed auto-repeat.
//   clk_148Mhz : pixel clock
//   reset      : asynchronous, active-high
//   bus        : move_scheduler_if.slave (buttons, frame_start, enable in; move_* out)
// Direction index: 0 = L, 1 = R, 2 = U, 3 = D.
module move_scheduler
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic              clk_148Mhz,
  input logic              reset,
  move_scheduler_if.slave  bus
);

  // One counter serves both DELAY and REPEAT, so size it for the larger.
  localparam int MAXP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXP + 1);

  logic [3:0]    raw;
  logic [3:0]    db;
  logic [3:0]    pending;
  logic          fs_q;
  logic          tick;
  logic          clr;
  move_state_t   state    [4];
  move_state_t   state_nx [4];
  logic [CW-1:0] cnt      [4];
  logic [CW-1:0] cnt_nx   [4];
  logic [3:0]    want;
  logic [3:0]    emit;
  logic [3:0]    move_q;

  assign raw  = {bus.btn_d_raw, bus.btn_u_raw, bus.btn_r_raw, bus.btn_l_raw};
  assign tick = bus.frame_start && !fs_q;
  assign clr  = tick || !bus.enable;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
      .clk_148Mhz (clk_148Mhz),
      .reset      (reset),
      .raw        (raw[g]),
      .clr        (clr),
      .db         (db[g]),
      .pending    (pending[g])
    );
  end

  // State register, frame_start edge register and registered move pulses.
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      fs_q   <= 1'b0;
      move_q <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      fs_q   <= bus.frame_start;
      move_q <= emit;
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
    end
  end

  // Next-state: FSMs move only on ticks; want[] is the unfiltered emit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      want[i]     = 1'b0;
      if (!bus.enable) begin
        state_nx[i] = IDLE;
        cnt_nx[i]   = '0;
      end else if (tick) begin
        if (pending[i]) begin
          want[i]     = 1'b1;
          state_nx[i] = DELAY;
          cnt_nx[i]   = CW'(1);
        end else begin
          case (state[i])
            IDLE: begin
              if (db[i]) begin
                want[i]     = 1'b1;
                state_nx[i] = DELAY;
                cnt_nx[i]   = CW'(1);
              end
            end
            DELAY: begin
              if (!db[i]) begin
                state_nx[i] = IDLE;
                cnt_nx[i]   = '0;
              end else if (cnt[i] == CW'(REPEAT_DELAY)) begin
                want[i]     = 1'b1;
                state_nx[i] = REPEAT;
                cnt_nx[i]   = CW'(1);
              end else begin
                cnt_nx[i] = cnt[i] + CW'(1);
              end
            end
            REPEAT: begin
              if (!db[i]) begin
                state_nx[i] = IDLE;
                cnt_nx[i]   = '0;
              end else if (cnt[i] == CW'(REPEAT_PERIOD)) begin
                want[i]   = 1'b1;
                cnt_nx[i] = CW'(1);
              end else begin
                cnt_nx[i] = cnt[i] + CW'(1);
              end
            end
            default: begin
              state_nx[i] = IDLE;
              cnt_nx[i]   = '0;
            end
          endcase
        end
      end
    end
  end

  // Output: opposing directions on the same tick cancel each other; the
  // FSMs above have already advanced as though both had fired.
  always_comb begin
    emit = want;
    if (want[0] && want[1]) emit[1:0] = 2'b00;
    if (want[2] && want[3]) emit[3:2] = 2'b00;
  end

  assign bus.move_l = move_q[0];
  assign bus.move_r = move_q[1];
  assign bus.move_u = move_q[2];
  assign bus.move_d = move_q[3];

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - self-checking bench for move_scheduler
module tb_move_scheduler;

  localparam int DB = 4;
  localparam int RD = 3;
  localparam int RP = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  move_scheduler_if bus ();

  move_scheduler #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_148Mhz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_count = 0;
  int base = 0;
  bit check_en = 1'b0;
  int ql[$], qr[$], qu[$], qd[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input int q[$], input int e[$]);
    chk({name, " count"}, q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk({name, " tick"}, (i < q.size()) ? q[i] : -1, e[i]);
  endtask

  // Frame ticks: 1-cycle pulse every 50 cycles, driven off the active edge.
  initial begin
    int fc;
    fc = 0;
    bus.frame_start = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      fc++;
      if (fc == 50) begin
        fc = 0;
        bus.frame_start = 1'b1;
        tick_count++;
      end else begin
        bus.frame_start = 1'b0;
      end
    end
  end

  // Behavioural model: debounced level per button, a pending-press flag, and
  // a "ticks since last start pulse" count k that decides pulses arithmetically.
  bit       m_s1 [4], m_s2 [4], m_db [4], m_dbp [4], m_pend [4], m_act [4];
  int       m_run [4], m_k [4];
  bit       m_fsp = 1'b0;
  bit [3:0] m_exp = '0;

  always @(posedge clk or posedge reset) begin
    bit [3:0] raw, w;
    bit       tk, en;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbp[i] = 0;
        m_pend[i] = 0; m_act[i] = 0; m_run[i] = 0; m_k[i] = 0;
      end
      m_fsp = 0;
      m_exp = '0;
    end else begin
      raw = {bus.btn_d_raw, bus.btn_u_raw, bus.btn_r_raw, bus.btn_l_raw};
      en  = bus.enable;
      tk  = bus.frame_start && !m_fsp;
      m_fsp = bus.frame_start;
      w = '0;
      for (int i = 0; i < 4; i++) begin
        if (!en) begin
          m_act[i] = 0;
        end else if (tk) begin
          if (m_pend[i] || (!m_act[i] && m_db[i])) begin
            w[i] = 1; m_act[i] = 1; m_k[i] = 0;
          end else if (m_act[i] && !m_db[i]) begin
            m_act[i] = 0;
          end else if (m_act[i]) begin
            m_k[i]++;
            if (m_k[i] == RD || (m_k[i] > RD && (m_k[i] - RD) % RP == 0)) w[i] = 1;
          end
        end
      end
      m_exp = w;
      if (w[0] && w[1]) m_exp[1:0] = 2'b00;
      if (w[2] && w[3]) m_exp[3:2] = 2'b00;
      for (int i = 0; i < 4; i++) begin
        if (tk || !en) m_pend[i] = 0;
        else if (m_db[i] && !m_dbp[i]) m_pend[i] = 1;
        m_dbp[i] = m_db[i];
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_db[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  end

  // Per-cycle compare against the model, and pulse logging by tick offset.
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      chk("move_l", int'(bus.move_l), int'(m_exp[0]));
      chk("move_r", int'(bus.move_r), int'(m_exp[1]));
      chk("move_u", int'(bus.move_u), int'(m_exp[2]));
      chk("move_d", int'(bus.move_d), int'(m_exp[3]));
      if (bus.move_l) ql.push_back(tick_count - base);
      if (bus.move_r) qr.push_back(tick_count - base);
      if (bus.move_u) qu.push_back(tick_count - base);
      if (bus.move_d) qd.push_back(tick_count - base);
    end
  end

  task automatic clear_q();
    ql.delete(); qr.delete(); qu.delete(); qd.delete();
  endtask

  // Land 2 cycles after a tick and make it the offset base.
  task automatic align();
    int t, n;
    t = tick_count;
    n = 0;
    while (tick_count == t && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (tick_count == t) chk("align timeout", 0, 1);
    repeat (2) @(negedge clk);
    base = tick_count;
    clear_q();
  endtask

  task automatic wait_ticks(input int n);
    int target, c;
    target = tick_count + n;
    c = 0;
    while (tick_count < target && c < n * 50 + 100) begin
      @(negedge clk);
      c++;
    end
    if (tick_count < target) chk("wait_ticks timeout", tick_count, target);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.btn_l_raw = 0; bus.btn_r_raw = 0; bus.btn_u_raw = 0; bus.btn_d_raw = 0;
    bus.enable = 1;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("reset move_l", int'(bus.move_l), 0);
    chk("reset move_r", int'(bus.move_r), 0);
    chk("reset move_u", int'(bus.move_u), 0);
    chk("reset move_d", int'(bus.move_d), 0);
    reset = 1'b0;

    // Clean L hold across 8 ticks.
    align();
    bus.btn_l_raw = 1;
    wait_ticks(8);
    check_q("l hold", ql, '{1, 4, 6, 8});
    bus.btn_l_raw = 0;
    wait_ticks(2);

    // R bouncing with 3-cycle half periods never debounces.
    align();
    for (int i = 0; i < 200; i++) begin
      bus.btn_r_raw = ((i / 3) % 2) == 0;
      @(negedge clk);
    end
    bus.btn_r_raw = 0;
    wait_ticks(2);
    check_q("r bounce", qr, '{});

    // Short U press between ticks: one pulse on the next tick.
    align();
    bus.btn_u_raw = 1;
    repeat (10) @(negedge clk);
    bus.btn_u_raw = 0;
    wait_ticks(3);
    check_q("u short", qu, '{1});

    // L+R cancel; L+U pass together.
    align();
    bus.btn_l_raw = 1; bus.btn_r_raw = 1;
    wait_ticks(8);
    check_q("lr conflict l", ql, '{});
    check_q("lr conflict r", qr, '{});
    bus.btn_l_raw = 0; bus.btn_r_raw = 0;
    wait_ticks(2);
    align();
    bus.btn_l_raw = 1; bus.btn_u_raw = 1;
    wait_ticks(4);
    check_q("lu diag l", ql, '{1, 4});
    check_q("lu diag u", qu, '{1, 4});
    bus.btn_l_raw = 0; bus.btn_u_raw = 0;
    wait_ticks(2);

    // D in REPEAT, disabled for 3 ticks, then re-enabled.
    align();
    bus.btn_d_raw = 1;
    wait_ticks(5);
    check_q("d pre", qd, '{1, 4});
    bus.enable = 0;
    clear_q();
    wait_ticks(3);
    check_q("d disabled", qd, '{});
    align();
    bus.enable = 1;
    wait_ticks(4);
    check_q("d reenable", qd, '{1, 4});

    // Reset mid-repeat with D held, right while a pulse is out.
    n = 0;
    while (!bus.move_d && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("d pulse seen", int'(bus.move_d), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("reset kills move_d", int'(bus.move_d), 0);
    repeat (3) @(negedge clk);
    clear_q();
    base = tick_count;
    reset = 1'b0;
    wait_ticks(6);
    check_q("d after reset", qd, '{1, 4, 6});

    bus.btn_d_raw = 0;
    wait_ticks(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequences movement commands for the on-screen object's position controller. Conditions the four raw direction buttons with synchronisation and debounce, then issues single-cycle move pulses aligned to the VGA frame tick, so the object moves at most one step per frame. A held button gives one immediate step followed by timed auto-repeat. Sits between the board buttons and the position-update block, in the 148.5 MHz (1080p) pixel domain.

## Interface
- DEBOUNCE_CYCLES, 1485000, consecutive stable cycles (10 ms) needed before a button state change is accepted; ≥2
- REPEAT_DELAY, 20, frame ticks from the first pulse of a hold to the second pulse; ≥1
- REPEAT_PERIOD, 4, frame ticks between subsequent repeat pulses; ≥1
- clk_148Mhz  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- btn_l_raw / btn_r_raw / btn_u_raw / btn_d_raw  in  1 each  raw, asynchronous, bouncy buttons
- frame_start  in  1  frame tick from VGA timing, synchronous; only its rising edge acts
- enable  in  1  synchronous; 0 = scheduler halted
- move_l / move_r / move_u / move_d  out  1 each  registered single-cycle move pulses to the position controller

## Operation
- Per button: 2-FF synchroniser feeds a debouncer. Debounced state db changes only after the synchronised input has differed from db for DEBOUNCE_CYCLES consecutive cycles. Any matching sample clears the counter.
- A db rising edge sets pending. pending clears on every tick.
- Tick = rising edge of frame_start. Per-direction FSM, evaluated only on ticks:
  - Any state, pending=1: emit a pulse, go to DELAY, cnt=1.
  - IDLE: db=1 → emit a pulse, go to DELAY, cnt=1. Otherwise stay.
  - DELAY: db=0 → IDLE. cnt==REPEAT_DELAY → emit a pulse, go to REPEAT, cnt=1. Otherwise cnt++.
  - REPEAT: db=0 → IDLE. cnt==REPEAT_PERIOD → emit a pulse, cnt=1. Otherwise cnt++.
- Conflict rule: if L and R would both emit on the same tick, both are suppressed; the same applies to U and D. The FSMs still advance as if they had emitted. Diagonal pairs, e.g. L+U, both pass.
- enable=0: FSMs are forced to IDLE, pending is cleared, and no pulses are emitted. Synchronisers and debouncers keep running. A button still held when enable returns to 1 pulses on the next tick (IDLE rule).
- Counter widths: $clog2(param+1). No wrap-around is possible by construction.

## Timing
- Reset values: all move_* = 0, all FSMs IDLE, cnt = 0, db = 0, pending = 0, synchronisers = 0, frame_start edge register = 0.
- Raw press to db: 2 cycles (synchroniser) + DEBOUNCE_CYCLES.
- move_* asserts exactly 1 cycle, on the cycle after the tick cycle. At most one pulse per direction per frame.
- A db rising edge on the same cycle as a tick is handled by the IDLE/db rule on that tick; pending is not left set.
- A press and release completed entirely between two ticks gives exactly one pulse, on the next tick.
- Reset asserted mid-operation clears everything immediately, including any pulse in flight.

## Structure
- Shared package vga_pkg: FSM state enum (IDLE, DELAY, REPEAT), H_ACTIVE=1920, V_ACTIVE=1080, default debounce/repeat constants.
- Sub-module btn_conditioner (synchroniser + debouncer + rising-edge pending flag), instantiated 4×.
- Top level holds the four FSMs, the conflict filter and the frame_start edge detect.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2. frame_start is a 1-cycle pulse every 50 cycles.
- Clean L hold across 8 ticks → move_l pulses on ticks 1, 4, 6, 8, each 1 cycle wide, the cycle after the tick.
- btn_r_raw toggling with 3-cycle high/low periods for 200 cycles → no move_r pulse.
- btn_u held 10 cycles, fully between two ticks → exactly one move_u pulse, at the next tick, then none.
- L+R held together → no move_l or move_r for 8 ticks. L+U held → move_l and move_u assert on the same cycles.
- D held in REPEAT; enable=0 for 3 ticks, then 1 → no pulses while disabled, a pulse on the first tick after re-enable, the next one 3 ticks later.
- Reset asserted mid-repeat with D held → move_d=0 immediately. After reset release: db re-debounces (2+4 cycles), one pulse on the next tick, then the normal repeat pattern.
